alsu_result_packer: RTL and testbench

- Downstream stage of the ALSU. Captures each registered 6-bit ALSU result and its 16-bit LED status the cycle the issue logic flags it valid.
- Packs valid results into wide words, buffers them in a small FIFO and presents them on a valid/ready stream to the host/debug port.
- Invalid-opcode results (leds != 0) are counted, never packed.

---
 rtl/alsu_pkg.sv | 13 +
 rtl/alsu_result_packer_if.sv | 36 +++
 rtl/alsu_word_fifo.sv | 45 ++++
 rtl/alsu_result_packer.sv | 108 ++++++++++
 tb/tb_alsu_result_packer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alsu_pkg.sv
// Shared ALSU result-packer types: result/LED widths, packed-word width helper
// and the per-word slot count type.
package alsu_pkg;
    localparam int ALSU_OUT_W = 6;
    localparam int ALSU_LED_W = 16;
    localparam int WORD_CNT_W = 4;

    typedef logic [WORD_CNT_W-1:0] word_cnt_t;

    function automatic int pack_w(input int pack_n);
        return pack_n * ALSU_OUT_W;
    endfunction
endpackage

// File: rtl/alsu_result_packer_if.sv
// Result-in / packed-word-out bus of the ALSU result packer.
// word_par exists only when ALSU_PACK_PARITY_EN is defined.
interface alsu_result_packer_if
    import alsu_pkg::*;
#(
    parameter int PACK_N = 4
);
    logic                    res_valid;
    logic [ALSU_OUT_W-1:0]   res_out;
    logic [ALSU_LED_W-1:0]   res_leds;
    logic                    res_ready;
    logic                    flush;
    logic [pack_w(PACK_N)-1:0] word_data;
    word_cnt_t               word_cnt;
    logic                    word_valid;
    logic                    word_ready;
`ifdef ALSU_PACK_PARITY_EN
    logic                    word_par;
`endif

    modport slave (
        input  res_valid, res_out, res_leds, flush, word_ready,
        output res_ready, word_data, word_cnt, word_valid
`ifdef ALSU_PACK_PARITY_EN
        , output word_par
`endif
    );

    modport master (
        output res_valid, res_out, res_leds, flush, word_ready,
        input  res_ready, word_data, word_cnt, word_valid
`ifdef ALSU_PACK_PARITY_EN
        , input word_par
`endif
    );
endinterface

// File: rtl/alsu_word_fifo.sv
// Generic synchronous FIFO; push is honoured when full if a pop happens the
// same cycle. Pointers carry an extra wrap bit for full/empty.
module alsu_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_d = wr_q + {{AW{1'b0}}, do_push};
    assign rd_d = rd_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign dout_o = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/alsu_result_packer.sv
// Packs valid ALSU results into PACK_N-slot words, queues them in a FIFO and
// counts invalid results. Optional word_par output under ALSU_PACK_PARITY_EN.
module alsu_result_packer
    import alsu_pkg::*;
#(
    parameter int PACK_N     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alsu_result_packer_if.slave  bus,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 drop_flag
);
    localparam int PW = pack_w(PACK_N);

    typedef struct packed {
        word_cnt_t       cnt;
        logic [PW-1:0]   data;
`ifdef ALSU_PACK_PARITY_EN
        logic            par;
`endif
    } rec_t;

    logic [PACK_N-1:0][ALSU_OUT_W-1:0] slot_q, slot_d, wslots;
    word_cnt_t        cnt_q, cnt_d, cnt_after;
    logic [ERR_W-1:0] err_q, err_d;
    logic             drop_q, drop_d;
    logic             full, empty, pop, push, space, res_rdy;
    logic             acc, acc_valid, acc_inv, complete;
    rec_t             push_rec, head_rec;

    assign pop     = !empty && bus.word_ready;
    assign space   = !full || pop;
    // Hold off the result that would complete a word with nowhere to put it.
    assign res_rdy = !((full && cnt_q == word_cnt_t'(PACK_N-1) && !pop) ||
                       (full && bus.flush && cnt_q != '0));

    assign acc       = bus.res_valid && res_rdy;
    assign acc_valid = acc && (bus.res_leds == '0);
    assign acc_inv   = acc && (bus.res_leds != '0);
    assign cnt_after = cnt_q + word_cnt_t'(acc_valid);
    assign complete  = (cnt_after == word_cnt_t'(PACK_N));
    assign push      = complete || (bus.flush && cnt_after != '0 && space);

    always_comb begin
        wslots = slot_q;
        for (int i = 0; i < PACK_N; i++) begin
            if (acc_valid && cnt_q == word_cnt_t'(i)) wslots[i] = bus.res_out;
        end
        push_rec      = '0;
        push_rec.cnt  = cnt_after;
        push_rec.data = wslots;
`ifdef ALSU_PACK_PARITY_EN
        push_rec.par  = ^{cnt_after, wslots};
`endif
        // Slots are cleared on every push so unused upper slots read as zero.
        if (push) begin
            slot_d = '0;
            cnt_d  = '0;
        end else begin
            slot_d = wslots;
            cnt_d  = cnt_after;
        end
        err_d = err_q;
        if (acc_inv && !(&err_q)) err_d = err_q + ERR_W'(1);
        drop_d = drop_q || (bus.res_valid && !res_rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    alsu_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(rec_t))
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .din_i   (push_rec),
        .pop_i   (pop),
        .dout_o  (head_rec),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.res_ready  = res_rdy;
    assign bus.word_valid = !empty;
    assign bus.word_data  = empty ? '0 : head_rec.data;
    assign bus.word_cnt   = empty ? '0 : head_rec.cnt;
`ifdef ALSU_PACK_PARITY_EN
    assign bus.word_par   = empty ? 1'b0 : head_rec.par;
`endif
    assign err_cnt        = err_q;
    assign drop_flag      = drop_q;
endmodule

// File: tb/tb_alsu_result_packer.sv
// Directed + random bench for alsu_result_packer against a queue-based model.
module tb_alsu_result_packer;
    import alsu_pkg::*;

    localparam int PACK_N = 4;
    localparam int DEPTH  = 4;
    localparam int ERR_W  = 8;
    localparam int PW     = PACK_N * 6;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    typedef struct {
        int            cnt;
        logic [PW-1:0] data;
    } w_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [ERR_W-1:0] err_cnt;
    logic             drop_flag;

    always #5 clk = ~clk;

    alsu_result_packer_if #(.PACK_N(PACK_N)) bus ();

    alsu_result_packer #(
        .PACK_N     (PACK_N),
        .FIFO_DEPTH (DEPTH),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_cnt   (err_cnt),
        .drop_flag (drop_flag)
    );

    logic [5:0] pk[$];
    w_t         fq[$];
    int         err_m;
    bit         drop_m;
    int         total;
    int         bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit r, input bit v, input logic [5:0] o,
                        input logic [15:0] l, input bit f, input bit wr);
        bit full, pop, rdy, space;
        logic [PW-1:0] d;
        @(negedge clk);
        rst = r;
        bus.res_valid = v;
        bus.res_out = o;
        bus.res_leds = l;
        bus.flush = f;
        bus.word_ready = wr;
        #1;
        full = (fq.size() == DEPTH);
        pop  = (fq.size() > 0) && wr;
        rdy  = !((full && pk.size() == PACK_N-1 && !pop) || (full && f && pk.size() > 0));
        chk("res_ready", 32'(bus.res_ready), 32'(rdy));
        chk("word_valid", 32'(bus.word_valid), 32'(fq.size() > 0));
        if (fq.size() > 0) begin
            chk("word_data", 32'(bus.word_data), 32'(fq[0].data));
            chk("word_cnt", 32'(bus.word_cnt), 32'(fq[0].cnt));
`ifdef ALSU_PACK_PARITY_EN
            chk("word_par", 32'(bus.word_par), 32'(^{4'(fq[0].cnt), fq[0].data}));
`endif
        end
        chk("err_cnt", 32'(err_cnt), 32'(err_m));
        chk("drop_flag", 32'(drop_flag), 32'(drop_m));
        @(posedge clk);
        if (r) begin
            pk.delete();
            fq.delete();
            err_m = 0;
            drop_m = 0;
        end else begin
            if (v && !rdy) drop_m = 1;
            if (v && rdy) begin
                if (l != 16'h0) begin
                    if (err_m < ERR_MAX) err_m++;
                end else begin
                    pk.push_back(o);
                end
            end
            space = !full || pop;
            if (pop) void'(fq.pop_front());
            if (pk.size() == PACK_N || (f && pk.size() > 0 && space)) begin
                d = '0;
                foreach (pk[i]) d |= PW'(pk[i]) << (6 * i);
                fq.push_back('{pk.size(), d});
                pk.delete();
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        err_m = 0;
        drop_m = 0;
        rst = 1'b1;
        bus.res_valid = 1'b0;
        bus.res_out = '0;
        bus.res_leds = '0;
        bus.flush = 1'b0;
        bus.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
        chk("rst_word_data", 32'(bus.word_data), 32'd0);
        chk("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_drop_flag", 32'(drop_flag), 32'd0);

        // Four valid results form one full word
        for (int i = 1; i <= 3; i++) step(0, 1, 6'(i), 16'h0, 0, 1);
        #1 chk("t1_not_yet", 32'(bus.word_valid), 32'd0);
        step(0, 1, 6'h04, 16'h0, 0, 1);
        #1;
        chk("t1_valid", 32'(bus.word_valid), 32'd1);
        chk("t1_data", 32'(bus.word_data), 32'h103081);
        chk("t1_cnt", 32'(bus.word_cnt), 32'd4);
        step(0, 0, 6'h0, 16'h0, 0, 1);

        // Invalid result skipped, partial word flushed
        step(0, 1, 6'h3F, 16'h0, 0, 1);
        step(0, 1, 6'h2A, 16'hFFFF, 0, 1);
        step(0, 1, 6'h15, 16'h0, 0, 1);
        step(0, 0, 6'h0, 16'h0, 1, 1);
        #1;
        chk("t2_data", 32'(bus.word_data), 32'h00057F);
        chk("t2_cnt", 32'(bus.word_cnt), 32'd2);
        chk("t2_err", 32'(err_cnt), 32'd1);
        step(0, 0, 6'h0, 16'h0, 0, 1);

        // Backpressure: fill FIFO, stall packer at PACK_N-1, then drop
        for (int i = 0; i < 20; i++) step(0, 1, 6'($urandom), 16'h0, 0, 0);
        #1 chk("t3_drop", 32'(drop_flag), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 6'h0, 16'h0, 0, 1);
        step(0, 0, 6'h0, 16'h0, 1, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 6'h0, 16'h0, 0, 1);

        // Push and pop together while full
        step(1, 0, 6'h0, 16'h0, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 1, 6'($urandom), 16'h0, 0, 0);
        step(0, 1, 6'h2B, 16'h0, 0, 1);
        #1;
        chk("t4_no_drop", 32'(drop_flag), 32'd0);
        chk("t4_valid", 32'(bus.word_valid), 32'd1);
        for (int i = 0; i < 6; i++) step(0, 0, 6'h0, 16'h0, 0, 1);

        // Error counter saturation
        step(1, 0, 6'h0, 16'h0, 0, 1);
        for (int i = 0; i < 300; i++) step(0, 1, 6'($urandom), 16'($urandom) | 16'h1, 0, 1);
        #1 chk("t5_err_sat", 32'(err_cnt), 32'hFF);

        // Reset mid-word and mid-handshake
        step(1, 0, 6'h0, 16'h0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, 6'($urandom), 16'h0, 0, 0);
        step(0, 1, 6'h11, 16'h1, 0, 0);
        step(1, 1, 6'h22, 16'h0, 1, 1);
        #1;
        chk("t6_valid", 32'(bus.word_valid), 32'd0);
        chk("t6_err", 32'(err_cnt), 32'd0);
        chk("t6_drop", 32'(drop_flag), 32'd0);
        step(0, 0, 6'h0, 16'h0, 1, 1);
        #1 chk("t6_flush_empty", 32'(bus.word_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 6'($urandom),
                 ($urandom_range(0, 7) == 0) ? 16'($urandom) | 16'h8 : 16'h0,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
